// File: rtl/axi_read_stream_pkg.sv
// rtl/axi_read_stream_pkg.sv - shared AXI constants, clogb2 and FSM encoding for the DDR frame masters
package axi_read_stream_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of bits needed to represent value (clogb2(7) = 3, clogb2(3) = 2).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/axi_read_stream.sv
// rtl/axi_read_stream.sv - AXI4 read master fetching a frame of INCR bursts and emitting it as a stream
module axi_read_stream
    import axi_read_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int AR_LEN     = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_num_bursts,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] o_rd_tdata,
    output logic                  o_rd_tvalid,
    output logic                  o_rd_tlast,
    input  logic                  i_rd_tready
);

    localparam int                    BEAT_BYTES  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(AR_LEN * BEAT_BYTES);
    localparam logic [7:0]            LAST_BEAT   = 8'(AR_LEN - 1);

    state_t                state_q;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  remain_q;
    logic [7:0]            beat_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic start_ok;
    logic start_frame;
    logic beat_xfer;
    logic beat_is_last;
    logic frame_last;
    logic beat_bad;
    logic unused_rid;

    assign start_ok     = (state_q == ST_IDLE) && i_start;
    assign start_frame  = start_ok && (i_num_bursts != '0);
    assign beat_xfer    = (state_q == ST_DATA) && m_axi_rvalid && i_rd_tready;
    assign beat_is_last = (beat_q == LAST_BEAT);
    assign frame_last   = (remain_q == CNT_WIDTH'(1));
    // The beat counter, not rlast, decides where a burst ends; a disagreeing rlast only flags an error.
    assign beat_bad     = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != beat_is_last);
    assign unused_rid   = m_axi_rid;

    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'(clogb2(BEAT_BYTES - 1));
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEFAULT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign o_rd_tdata    = m_axi_rdata;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state plus the state-gated handshake and stream outputs.
    always_comb begin
        state_nxt     = state_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        o_rd_tvalid   = 1'b0;
        o_rd_tlast    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_frame) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = i_rd_tready;
                o_rd_tvalid  = m_axi_rvalid;
                o_rd_tlast   = beat_is_last && frame_last;
                if (beat_xfer && beat_is_last) begin
                    state_nxt = frame_last ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame address, burst and beat counters, plus the busy/done/err status flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                err_q <= 1'b0;
                if (start_frame) begin
                    addr_q   <= i_base_addr;
                    remain_q <= i_num_bursts;
                    beat_q   <= '0;
                    busy_q   <= 1'b1;
                end else begin
                    done_q <= 1'b1;
                end
            end
            if (beat_xfer) begin
                if (beat_bad) begin
                    err_q <= 1'b1;
                end
                if (beat_is_last) begin
                    beat_q   <= '0;
                    addr_q   <= addr_q + BURST_BYTES;
                    remain_q <= remain_q - CNT_WIDTH'(1);
                    if (frame_last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end else begin
                    beat_q <= beat_q + 8'd1;
                end
            end
        end
    end

endmodule
